// File: rtl/data_array_arb.sv
`default_nettype none
// ============================================================================
// Module  : data_array_arb
// Purpose : Arbiter/sequencer sharing the single-ported data RAM between LSU
//           bank reads, refill line writes and two-beat writeback line reads.
//           Read and write never issue together; LSU is promoted after
//           STARVE_MAX consecutive lost cycles.
// Ports   : clk, rst (async, active-high)
//           lsu_req_*     - LSU one-bank read request / handshake
//           refill_req_*  - full-line refill write request / handshake
//           wb_req_*      - writeback line read request / handshake
//           lsu_rsp_valid_o, wb_rsp_valid_o, wb_rsp_beat_o - response strobes
//           rd_req_*, wr_req_* - array read / write port requests
// Revision: 1.0 - initial release
// ============================================================================
module data_array_arb #(
    parameter int CACHE_IDX_W  = 6,
    parameter int CACHE_BANK_N = 8,
    parameter int CACHE_WAY_N  = 4,
    parameter int CACHE_BANK_W = 64,
    parameter int STARVE_MAX   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 lsu_req_valid_i,
    output logic                                 lsu_req_ready_o,
    input  logic [CACHE_IDX_W-1:0]               lsu_req_idx_i,
    input  logic [CACHE_BANK_N-1:0]              lsu_req_bank_i,
    input  logic                                 refill_req_valid_i,
    output logic                                 refill_req_ready_o,
    input  logic [CACHE_IDX_W-1:0]               refill_req_idx_i,
    input  logic [CACHE_WAY_N-1:0]               refill_req_way_i,
    input  logic [CACHE_BANK_W*CACHE_BANK_N-1:0] refill_req_data_i,
    input  logic                                 wb_req_valid_i,
    output logic                                 wb_req_ready_o,
    input  logic [CACHE_IDX_W-1:0]               wb_req_idx_i,
    input  logic [CACHE_WAY_N-1:0]               wb_req_way_i,
    output logic                                 lsu_rsp_valid_o,
    output logic                                 wb_rsp_valid_o,
    output logic                                 wb_rsp_beat_o,
    output logic                                 rd_req_valid_o,
    output logic [CACHE_IDX_W-1:0]               rd_req_idx_o,
    output logic [CACHE_BANK_N-1:0]              rd_req_bank_en_o,
    output logic [CACHE_WAY_N-1:0]               rd_req_way_o,
    output logic                                 wr_req_valid_o,
    output logic [CACHE_IDX_W-1:0]               wr_req_idx_o,
    output logic [CACHE_BANK_N-1:0]              wr_req_bank_en_o,
    output logic [CACHE_WAY_N-1:0]               wr_req_way_o,
    output logic [CACHE_BANK_W*CACHE_BANK_N-1:0] wr_req_data_o
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam int                HALF_N     = CACHE_BANK_N / 2;
    localparam logic [CACHE_BANK_N-1:0] BEAT0_EN = {{HALF_N{1'b0}}, {HALF_N{1'b1}}};
    localparam logic [CACHE_BANK_N-1:0] BEAT1_EN = {{HALF_N{1'b1}}, {HALF_N{1'b0}}};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WB_B1 = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic [CACHE_IDX_W-1:0] wb_idx_q;
    logic [CACHE_WAY_N-1:0] wb_way_q;
    logic                   lsu_rsp_q, wb_rsp_q, wb_beat_q;

    logic                   idle, in_b1, starve;
    logic                   lsu_gnt, refill_gnt, wb_gnt;

    // Arbitration is gated by rst so nothing is granted or issued while the
    // block is held in reset (outputs are combinational from the valids).
    assign idle   = (state_q == S_IDLE) && !rst;
    assign in_b1  = (state_q == S_WB_B1) && !rst;
    assign starve = (starve_cnt_q == STARVE_LIM);

    // Starved: LSU > refill > WB. Otherwise: refill > WB > LSU.
    assign lsu_gnt    = idle && lsu_req_valid_i &&
                        (starve || !(refill_req_valid_i || wb_req_valid_i));
    assign refill_gnt = idle && refill_req_valid_i && !(starve && lsu_req_valid_i);
    assign wb_gnt     = idle && wb_req_valid_i && !refill_req_valid_i &&
                        !(starve && lsu_req_valid_i);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (wb_gnt) state_d = S_WB_B1;
            S_WB_B1: state_d = S_IDLE;   // second beat is never interrupted
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Fields stay 0 whenever their valid is 0: the array ORs idx inputs.
    always_comb begin
        lsu_req_ready_o    = lsu_gnt;
        refill_req_ready_o = refill_gnt;
        wb_req_ready_o     = wb_gnt;
        rd_req_valid_o     = 1'b0;
        rd_req_idx_o       = '0;
        rd_req_bank_en_o   = '0;
        rd_req_way_o       = '0;
        wr_req_valid_o     = 1'b0;
        wr_req_idx_o       = '0;
        wr_req_bank_en_o   = '0;
        wr_req_way_o       = '0;
        wr_req_data_o      = '0;
        if (lsu_gnt) begin
            rd_req_valid_o   = 1'b1;
            rd_req_idx_o     = lsu_req_idx_i;
            rd_req_bank_en_o = lsu_req_bank_i;
            rd_req_way_o     = '1;
        end else if (wb_gnt) begin
            rd_req_valid_o   = 1'b1;
            rd_req_idx_o     = wb_req_idx_i;
            rd_req_bank_en_o = BEAT0_EN;
            rd_req_way_o     = wb_req_way_i;
        end else if (in_b1) begin
            rd_req_valid_o   = 1'b1;
            rd_req_idx_o     = wb_idx_q;
            rd_req_bank_en_o = BEAT1_EN;
            rd_req_way_o     = wb_way_q;
        end
        if (refill_gnt) begin
            wr_req_valid_o   = 1'b1;
            wr_req_idx_o     = refill_req_idx_i;
            wr_req_bank_en_o = '1;
            wr_req_way_o     = refill_req_way_i;
            wr_req_data_o    = refill_req_data_i;
        end
    end

    // Starvation counter: counts every cycle the LSU waits, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lsu_req_valid_i || lsu_gnt) begin
            starve_cnt_d = '0;
        end else if (!starve) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
            wb_idx_q     <= '0;
            wb_way_q     <= '0;
            lsu_rsp_q    <= 1'b0;
            wb_rsp_q     <= 1'b0;
            wb_beat_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if (wb_gnt) begin
                wb_idx_q <= wb_req_idx_i;
                wb_way_q <= wb_req_way_i;
            end
            // Response strobes trail the issue by the 1-cycle RAM latency.
            lsu_rsp_q <= lsu_gnt;
            wb_rsp_q  <= wb_gnt || (state_q == S_WB_B1);
            wb_beat_q <= (state_q == S_WB_B1);
        end
    end

    assign lsu_rsp_valid_o = lsu_rsp_q;
    assign wb_rsp_valid_o  = wb_rsp_q;
    assign wb_rsp_beat_o   = wb_beat_q;

endmodule
`default_nettype wire

// File: tb/tb_data_array_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_array_arb
// Purpose : Directed + random self-checking bench for data_array_arb with a
//           transaction-level reference model (winner pick, starvation count,
//           pending second WB beat, expected response strobes).
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_array_arb;
    localparam int IW = 6, BN = 8, WN = 4, BW = 64, SM = 8;
    localparam int NONE = 0, LSU = 1, REF = 2, WB = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic lsu_v = 0, ref_v = 0, wb_v = 0;
    logic [IW-1:0] lsu_idx = '0, ref_idx = '0, wb_idx = '0;
    logic [BN-1:0] lsu_bank = '0;
    logic [WN-1:0] ref_way = '0, wb_way = '0;
    logic [BW*BN-1:0] ref_data = '0;
    logic lsu_rdy, ref_rdy, wb_rdy, lsu_rsp, wb_rsp, wb_beat;
    logic rd_v, wr_v;
    logic [IW-1:0] rd_idx, wr_idx;
    logic [BN-1:0] rd_bank, wr_bank;
    logic [WN-1:0] rd_way, wr_way;
    logic [BW*BN-1:0] wr_data;

    data_array_arb #(.CACHE_IDX_W(IW), .CACHE_BANK_N(BN), .CACHE_WAY_N(WN),
                     .CACHE_BANK_W(BW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_valid_i(lsu_v), .lsu_req_ready_o(lsu_rdy),
        .lsu_req_idx_i(lsu_idx), .lsu_req_bank_i(lsu_bank),
        .refill_req_valid_i(ref_v), .refill_req_ready_o(ref_rdy),
        .refill_req_idx_i(ref_idx), .refill_req_way_i(ref_way),
        .refill_req_data_i(ref_data),
        .wb_req_valid_i(wb_v), .wb_req_ready_o(wb_rdy),
        .wb_req_idx_i(wb_idx), .wb_req_way_i(wb_way),
        .lsu_rsp_valid_o(lsu_rsp), .wb_rsp_valid_o(wb_rsp), .wb_rsp_beat_o(wb_beat),
        .rd_req_valid_o(rd_v), .rd_req_idx_o(rd_idx),
        .rd_req_bank_en_o(rd_bank), .rd_req_way_o(rd_way),
        .wr_req_valid_o(wr_v), .wr_req_idx_o(wr_idx),
        .wr_req_bank_en_o(wr_bank), .wr_req_way_o(wr_way), .wr_req_data_o(wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    // Reference model state
    int            m_cnt = 0;        // consecutive cycles LSU has waited
    bit            m_b1  = 0;        // second WB beat owed next cycle
    logic [IW-1:0] m_idx = '0;
    logic [WN-1:0] m_way = '0;
    bit            e_lsu_rsp = 0, e_wb_rsp = 0, e_beat = 0;
    int            last_win = NONE;
    bit            obs_lsu_rdy;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        int order [3];
        if (m_b1) return NONE;
        if (m_cnt >= SM) order = '{LSU, REF, WB};
        else             order = '{REF, WB, LSU};
        foreach (order[k]) begin
            if (order[k] == LSU && lsu_v) return LSU;
            if (order[k] == REF && ref_v) return REF;
            if (order[k] == WB  && wb_v)  return WB;
        end
        return NONE;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_b1 = 0; m_idx = '0; m_way = '0;
        e_lsu_rsp = 0; e_wb_rsp = 0; e_beat = 0; last_win = NONE;
    endtask

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic cycle();
        int w;
        logic [IW+BN+WN:0]   e_rd;
        logic [IW+BN+WN:0]   e_wr;
        #3;
        w = pick();
        obs_lsu_rdy = lsu_rdy;
        chk("ready", {lsu_rdy, ref_rdy, wb_rdy}, {w == LSU, w == REF, w == WB});
        e_rd = '0;
        if (w == LSU)     e_rd = {1'b1, lsu_idx, lsu_bank, {WN{1'b1}}};
        else if (w == WB) e_rd = {1'b1, wb_idx, 8'h0F, wb_way};
        else if (m_b1)    e_rd = {1'b1, m_idx, 8'hF0, m_way};
        chk("rd_req", {rd_v, rd_idx, rd_bank, rd_way}, e_rd);
        e_wr = (w == REF) ? {1'b1, ref_idx, 8'hFF, ref_way} : '0;
        chk("wr_req", {wr_v, wr_idx, wr_bank, wr_way}, e_wr);
        chk("wr_data", wr_data, (w == REF) ? ref_data : '0);
        chk("rd_wr_excl", rd_v & wr_v, 1'b0);
        @(posedge clk);
        e_lsu_rsp = (w == LSU);
        e_wb_rsp  = (w == WB) || m_b1;
        e_beat    = m_b1;
        if (w == WB) begin m_idx = wb_idx; m_way = wb_way; end
        m_b1 = (w == WB);
        if (!lsu_v || w == LSU) m_cnt = 0;
        else if (m_cnt < SM)    m_cnt++;
        last_win = w;
        #1;
        chk("rsp", {lsu_rsp, wb_rsp, wb_beat}, {e_lsu_rsp, e_wb_rsp, e_beat});
    endtask

    task automatic new_lsu();
        int b;
        b = $urandom_range(0, BN - 1);
        lsu_v = 1; lsu_idx = IW'($urandom); lsu_bank = BN'(1) << b;
    endtask
    task automatic new_ref();
        ref_v = 1; ref_idx = IW'($urandom); ref_way = WN'(1) << $urandom_range(0, WN - 1);
        for (int k = 0; k < BN * 2; k++) ref_data[k*32 +: 32] = $urandom;
    endtask
    task automatic new_wb();
        wb_v = 1; wb_idx = IW'($urandom); wb_way = WN'(1) << $urandom_range(0, WN - 1);
    endtask

    initial begin
        int first;
        // ---- reset: readies/requests stay 0 even with every valid high ----
        new_lsu(); new_ref(); new_wb();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {lsu_rdy, ref_rdy, wb_rdy}, 3'b000);
        chk("rst_arr", {rd_v, rd_idx, rd_bank, rd_way, wr_v, wr_idx, wr_bank, wr_way}, '0);
        chk("rst_rsp", {lsu_rsp, wb_rsp, wb_beat}, 3'b000);
        lsu_v = 0; ref_v = 0; wb_v = 0;
        rst = 0;
        model_reset();

        // ---- LSU only, idx 5, bank 04 ----
        lsu_v = 1; lsu_idx = 6'd5; lsu_bank = 8'h04;
        cycle();
        lsu_v = 0;
        cycle();

        // ---- all three valid: refill, WB b0, WB b1, then LSU ----
        new_lsu(); new_ref(); new_wb();
        cycle();                      // refill wins
        ref_v = 0;
        cycle();                      // WB beat 0
        wb_v = 0;
        cycle();                      // WB beat 1, LSU blocked
        chk("b1_lsu_blocked", obs_lsu_rdy, 1'b0);
        cycle();                      // LSU granted
        chk("lsu_after_wb", obs_lsu_rdy, 1'b1);
        lsu_v = 0;
        cycle();

        // ---- WB idx 3, way 0100 ----
        wb_v = 1; wb_idx = 6'd3; wb_way = 4'b0100;
        cycle();
        wb_v = 0;
        cycle();
        cycle();

        // ---- starvation: continuous refill + LSU ----
        new_lsu();
        first = 0;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            new_ref();
            cycle();
            if (obs_lsu_rdy) first = i;
        end
        chk("starve_grant_cycle", first, 9);
        new_lsu();                    // counter restarted: next win again at 9
        first = 0;
        for (int i = 1; i <= 12 && first == 0; i++) begin
            new_ref();
            cycle();
            if (obs_lsu_rdy) first = i;
        end
        chk("starve_regrant_cycle", first, 9);
        lsu_v = 0; ref_v = 0;
        cycle();

        // ---- reset during WB_B1 ----
        new_wb();
        cycle();                      // beat 0 issued, now in WB_B1
        wb_v = 0;
        rst = 1;
        #1;
        chk("b1rst_arr", {rd_v, wr_v, lsu_rdy, ref_rdy, wb_rdy}, 5'b0);
        chk("b1rst_rsp", {lsu_rsp, wb_rsp, wb_beat}, 3'b000);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        cycle();                      // no stray WB response after release
        new_lsu();
        cycle();
        chk("post_rst_lsu", obs_lsu_rdy, 1'b1);
        lsu_v = 0;
        cycle();

        // ---- random traffic ----
        for (int n = 0; n < 3000; n++) begin
            if (last_win == LSU || (lsu_v && $urandom_range(0, 7) == 0)) lsu_v = 0;
            else if (!lsu_v && $urandom_range(0, 1) == 1) new_lsu();
            if (last_win == REF) ref_v = 0;
            else if (!ref_v && $urandom_range(0, 3) == 0) new_ref();
            if (last_win == WB) wb_v = 0;
            else if (!wb_v && $urandom_range(0, 3) == 0) new_wb();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
